// File: rtl/nco_phase.sv
// Phase-accumulator NCO feeding the sincos phase input. It holds a fixed
// frequency or runs a linear chirp, and supports a static phase offset and a sync-to-zero event.
module nco_phase #(
  parameter int NBA = 48,
  parameter int NBP = 26
) (
  input  logic           c,
  input  logic           r,
  input  logic           wr,
  input  logic [NBA-1:0] f_start,
  input  logic [NBA-1:0] f_step,
  input  logic [31:0]    n_steps,
  input  logic [NBP-1:0] p_off,
  input  logic           sync,
  output logic           busy,
  output logic [NBP-1:0] o_phase
);

  typedef enum logic {FIXED, SWEEP} state_t;

  state_t         state_q, state_d;
  logic [NBA-1:0] freq_q, freq_d;
  logic [NBA-1:0] step_q, step_d;
  logic [NBA-1:0] acc_q, acc_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           busy_q;
  logic [NBP-1:0] phase_q, phase_d;

  // A write wins over an in-flight increment and restarts the sweep.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (wr) begin
      freq_d  = f_start;
      step_d  = f_step;
      cnt_d   = n_steps;
      state_d = (n_steps != 32'd0) ? SWEEP : FIXED;
    end else if (state_q == SWEEP) begin
      freq_d = freq_q + step_q;
      cnt_d  = cnt_q - 32'd1;
      if (cnt_q == 32'd1) state_d = FIXED;
    end
  end

  // The accumulator uses the pre-update frequency. Sync only touches the accumulator.
  always_comb begin
    acc_d   = sync ? '0 : acc_q + freq_q;
    phase_d = acc_q[NBA-1 -: NBP] + p_off;
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= FIXED;
      freq_q  <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == SWEEP);
      phase_q <= phase_d;
    end
  end

  assign busy    = busy_q;
  assign o_phase = phase_q;

endmodule
